opcode_match_unit: RTL and testbench

OPCODE_MATCH_UNIT -- requirements
Module: opcode_match_unit

---
 rtl/opcode_match_unit_if.sv | 33 +++
 rtl/opcode_match_unit.sv | 81 ++++++++
 tb/tb_opcode_match_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/opcode_match_unit_if.sv
// opcode_match_unit_if: instruction, configuration and hit-report bundle for opcode_match_unit.
// master drives instructions, configuration and counter control; slave is the matcher.
interface opcode_match_unit_if #(
   parameter int WIDTH = 16,
   parameter int NPAT  = 4,
   parameter int CNTW  = 8
);
   localparam int SW = $clog2(NPAT);
   logic [WIDTH-1:0] i_instr;
   logic             i_valid;
   logic             i_cfg_we;
   logic [SW-1:0]    i_cfg_sel;
   logic [WIDTH-1:0] i_cfg_val;
   logic [WIDTH-1:0] i_cfg_mask;
   logic             i_cfg_en;
   logic [NPAT-1:0]  o_hit;
   logic             o_hit_valid;
   logic             o_any_hit;
   logic [SW-1:0]    o_hit_idx;
   logic [SW-1:0]    i_cnt_sel;
   logic             i_cnt_clr;
   logic [CNTW-1:0]  o_cnt;
   modport master (
      output i_instr, i_valid, i_cfg_we, i_cfg_sel, i_cfg_val, i_cfg_mask, i_cfg_en,
      output i_cnt_sel, i_cnt_clr,
      input  o_hit, o_hit_valid, o_any_hit, o_hit_idx, o_cnt
   );
   modport slave (
      input  i_instr, i_valid, i_cfg_we, i_cfg_sel, i_cfg_val, i_cfg_mask, i_cfg_en,
      input  i_cnt_sel, i_cnt_clr,
      output o_hit, o_hit_valid, o_any_hit, o_hit_idx, o_cnt
   );
endinterface

// File: rtl/opcode_match_unit.sv
// opcode_match_unit: masked multi-channel opcode matcher with one-cycle registered hit report.
// Defining OPCODE_MATCH_HIT_COUNT_EN adds per-channel saturating hit counters.
module opcode_match_unit #(
   parameter int WIDTH = 16,
   parameter int NPAT  = 4,
   parameter int CNTW  = 8
) (
   input logic clk,
   input logic rst,
   opcode_match_unit_if.slave bus
);
   localparam int SW = $clog2(NPAT);
   logic [WIDTH-1:0] r_val  [NPAT];
   logic [WIDTH-1:0] r_mask [NPAT];
   logic [NPAT-1:0]  r_en;
   logic [NPAT-1:0]  r_hit;
   logic             r_hit_valid;
   logic             r_any_hit;
   logic [SW-1:0]    r_hit_idx;
   logic [NPAT-1:0]  w_match;
   logic [SW-1:0]    w_idx;
   logic             w_cfg_ok;
   assign w_cfg_ok = 32'(bus.i_cfg_sel) < NPAT;
   // Channel 0 comes out of reset decoding MOVI (low byte 0x02).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NPAT; k++) begin
            r_val[k]  <= (k == 0) ? WIDTH'(16'h0002) : '0;
            r_mask[k] <= (k == 0) ? WIDTH'(16'h00FF) : '0;
            r_en[k]   <= (k == 0);
         end
      end else if (bus.i_cfg_we && w_cfg_ok) begin
         r_val[bus.i_cfg_sel]  <= bus.i_cfg_val;
         r_mask[bus.i_cfg_sel] <= bus.i_cfg_mask;
         r_en[bus.i_cfg_sel]   <= bus.i_cfg_en;
      end
   end
   always_comb begin
      w_match = '0;
      for (int k = 0; k < NPAT; k++)
         w_match[k] = r_en[k] && (((bus.i_instr ^ r_val[k]) & r_mask[k]) == '0);
   end
   always_comb begin
      w_idx = '0;
      for (int k = NPAT - 1; k >= 0; k--)
         if (w_match[k]) w_idx = SW'(k);
   end
   always_ff @(posedge clk) begin
      if (rst || !bus.i_valid) begin
         r_hit     <= '0;
         r_any_hit <= 1'b0;
         r_hit_idx <= '0;
      end else begin
         r_hit     <= w_match;
         r_any_hit <= |w_match;
         r_hit_idx <= w_idx;
      end
      r_hit_valid <= !rst && bus.i_valid;
   end
   assign bus.o_hit       = r_hit;
   assign bus.o_hit_valid = r_hit_valid;
   assign bus.o_any_hit   = r_any_hit;
   assign bus.o_hit_idx   = r_hit_idx;
`ifdef OPCODE_MATCH_HIT_COUNT_EN
   logic [CNTW-1:0] r_cnt [NPAT];
   // Clear beats a coincident increment on the same channel.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NPAT; k++) begin
         if (rst || (bus.i_cnt_clr && 32'(bus.i_cnt_sel) == k))
            r_cnt[k] <= '0;
         else if (r_hit[k] && r_cnt[k] != '1)
            r_cnt[k] <= r_cnt[k] + 1'b1;
      end
   end
   assign bus.o_cnt = (32'(bus.i_cnt_sel) < NPAT) ? r_cnt[bus.i_cnt_sel] : '0;
`else
   logic w_unused;
   assign w_unused  = ^{bus.i_cnt_sel, bus.i_cnt_clr};
   assign bus.o_cnt = '0;
`endif
endmodule

// File: tb/tb_opcode_match_unit.sv
// tb_opcode_match_unit: randomized and directed checks of opcode_match_unit against an array-based model.
module tb_opcode_match_unit;
   localparam int WIDTH = 16;
   localparam int NPAT  = 6;
   localparam int CNTW  = 8;
   localparam int SW    = $clog2(NPAT);
   localparam int CMAX  = (1 << CNTW) - 1;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   opcode_match_unit_if #(.WIDTH(WIDTH), .NPAT(NPAT), .CNTW(CNTW)) bus ();
   opcode_match_unit #(.WIDTH(WIDTH), .NPAT(NPAT), .CNTW(CNTW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   logic [WIDTH-1:0] m_val  [NPAT];
   logic [WIDTH-1:0] m_mask [NPAT];
   logic             m_en   [NPAT];
   int               m_cnt  [NPAT];
   logic [NPAT-1:0]  m_hit;
   logic             m_hv;
   int               m_idx;
   int n_tests = 0;
   int n_fail  = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [WIDTH-1:0] ii, input logic we = 1'b0,
                        input int sel = 0, input logic [WIDTH-1:0] val = '0,
                        input logic [WIDTH-1:0] mask = '0, input logic en = 1'b0,
                        input int csel = 0, input logic cclr = 1'b0);
      bus.i_valid    = v;
      bus.i_instr    = ii;
      bus.i_cfg_we   = we;
      bus.i_cfg_sel  = SW'(sel);
      bus.i_cfg_val  = val;
      bus.i_cfg_mask = mask;
      bus.i_cfg_en   = en;
      bus.i_cnt_sel  = SW'(csel);
      bus.i_cnt_clr  = cclr;
   endtask
   // One clock: update the model from the inputs seen at the edge, then compare.
   task automatic tick();
      logic [NPAT-1:0] prev;
      int csel;
      int ecnt;
      @(posedge clk);
      prev = m_hit;
      if (rst) begin
         for (int k = 0; k < NPAT; k++) begin
            m_val[k]  = (k == 0) ? WIDTH'(16'h0002) : '0;
            m_mask[k] = (k == 0) ? WIDTH'(16'h00FF) : '0;
            m_en[k]   = (k == 0);
            m_cnt[k]  = 0;
         end
         m_hit = '0;
         m_hv  = 1'b0;
         m_idx = 0;
      end else begin
         m_hit = '0;
         m_idx = 0;
         m_hv  = bus.i_valid;
         if (bus.i_valid)
            for (int k = 0; k < NPAT; k++)
               m_hit[k] = m_en[k] && (((bus.i_instr ^ m_val[k]) & m_mask[k]) == 0);
         for (int k = 0; k < NPAT; k++)
            if (m_hit[k]) begin
               m_idx = k;
               break;
            end
         for (int k = 0; k < NPAT; k++)
            if (bus.i_cnt_clr && int'(bus.i_cnt_sel) == k) m_cnt[k] = 0;
            else if (prev[k] && m_cnt[k] < CMAX) m_cnt[k]++;
         if (bus.i_cfg_we && int'(bus.i_cfg_sel) < NPAT) begin
            m_val[bus.i_cfg_sel]  = bus.i_cfg_val;
            m_mask[bus.i_cfg_sel] = bus.i_cfg_mask;
            m_en[bus.i_cfg_sel]   = bus.i_cfg_en;
         end
      end
      #1;
      csel = int'(bus.i_cnt_sel);
`ifdef OPCODE_MATCH_HIT_COUNT_EN
      ecnt = (csel < NPAT) ? m_cnt[csel] : 0;
`else
      ecnt = 0;
`endif
      chk("hit", 32'(bus.o_hit), 32'(m_hit));
      chk("hit_valid", 32'(bus.o_hit_valid), 32'(m_hv));
      chk("any_hit", 32'(bus.o_any_hit), 32'(|m_hit));
      chk("hit_idx", 32'(bus.o_hit_idx), 32'(m_idx));
      chk("cnt", 32'(bus.o_cnt), 32'(ecnt));
   endtask
   initial begin
      logic [WIDTH-1:0] w;
      int ch;
      rst = 1'b1;
      drive(1'b0, '0);
      tick();
      chk("rst_hv", 32'(bus.o_hit_valid), 0);
      tick();
      rst = 1'b0;
      drive(1'b1, 16'hAB02);
      tick();
      chk("movi_hit", 32'(bus.o_hit), 32'h1);
      chk("movi_idx", 32'(bus.o_hit_idx), 0);
      drive(1'b1, 16'hAB03);
      tick();
      chk("movi_miss", 32'(bus.o_any_hit), 0);
      drive(1'b1, 16'h1202, 1'b1, 2, 16'h1200, 16'hFF00, 1'b1);
      tick();
      chk("cfg_old", 32'(bus.o_hit), 32'h1);
      drive(1'b1, 16'h1202);
      tick();
      chk("cfg_new", 32'(bus.o_hit), 32'h5);
      chk("cfg_idx", 32'(bus.o_hit_idx), 0);
      drive(1'b0, 16'h1202);
      tick();
      chk("idle_hv", 32'(bus.o_hit_valid), 0);
      drive(1'b1, 16'h0000, 1'b1, 4, 16'h0000, 16'h0000, 1'b1);
      tick();
      drive(1'b1, 16'h7F55);
      tick();
      chk("mask0_all", 32'(bus.o_hit), 32'h10);
      chk("mask0_idx", 32'(bus.o_hit_idx), 4);
      drive(1'b1, 16'h0002, 1'b1, 7, 16'h0000, 16'h0000, 1'b1);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(k != 2 && k != 4, 16'h1202);
         tick();
      end
      drive(1'b1, 16'h1202);
      tick();
      rst = 1'b1;
      drive(1'b1, 16'h1202);
      tick();
      chk("rst_discard", 32'(bus.o_hit_valid), 0);
      rst = 1'b0;
      drive(1'b1, 16'h1202);
      tick();
      chk("rst_cfg", 32'(bus.o_hit), 32'h1);
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 16'h0002);
         tick();
      end
`ifdef OPCODE_MATCH_HIT_COUNT_EN
      chk("cnt_sat", 32'(bus.o_cnt), 255);
`endif
      drive(1'b0, '0, 1'b0, 0, '0, '0, 1'b0, 0, 1'b1);
      tick();
      chk("cnt_clr", 32'(bus.o_cnt), 0);
      drive(1'b0, '0);
      tick();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         ch = $urandom_range(0, NPAT - 1);
         w = WIDTH'($urandom);
         if ($urandom_range(0, 1) == 1) w = m_val[ch] ^ (WIDTH'($urandom) & ~m_mask[ch]);
         drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 6) == 0,
               $urandom_range(0, 7), WIDTH'($urandom),
               ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 19) == 0);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
